serial_loader: RTL
==================

# serial_loader

Bus-master monitor between the on-board UART and the system memory bus. It polls the UART's status and data registers, decodes a small binary command protocol, and writes or reads memory on behalf of a host PC. It holds the CPU off the bus while it works and releases the CPU at a host-supplied start address. It is the initiator counterpart of the UART's register-responder interface and sits beside the CPU in the board top level.

## Interface
Parameters:
- `HOLD_AT_RESET`, 1: `cpu_hold` is asserted out of reset until the first `G` command.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `u_cs`  out  1  UART chip select.
- `u_a0`  out  1  UART register select: 0 = status, 1 = data.
- `u_rnw`  out  1  UART read (1) / write (0).
- `u_wdata`  out  8  byte to UART (TX).
- `u_rdata`  in  8  UART read data, combinational from the UART. Status bit0 = rx_full, bit1 = tx_busy.
- `m_addr`  out  16  memory address.
- `m_wdata`  out  8  memory write data.
- `m_we`  out  1  one-cycle write strobe.
- `m_re`  out  1  one-cycle read strobe; `m_rdata` is valid the following cycle.
- `m_rdata`  in  8  memory read data.
- `cpu_hold`  out  1  CPU must tri-state / stall while high.
- `go`  out  1  one-cycle pulse: CPU restarts at `go_addr`.
- `go_addr`  out  16  start address, held until the next `G`.

## Operation
Protocol (host → loader):
- `W` (0x57) AH AL LEN D0..Dn-1
  - Writes n bytes from {AH,AL} upward.
  - Replies with one byte: the 8-bit sum of the data bytes.
- `R` (0x52) AH AL LEN
  - Replies with n bytes read from {AH,AL} upward.
- `G` (0x47) AH AL
  - Sets `go_addr`, pulses `go`, drops `cpu_hold`.
  - Replies 0x2E ('.').
- Any other command byte: replies 0x3F ('?'), then returns to IDLE.

Rules:
- LEN = 0 means 256 bytes.
- Address increments mod 2^16 (0xFFFF → 0x0000).
- The checksum wraps mod 256.

RX byte fetch (3 cycles minimum):
1. STAT: `u_cs`=1, `u_a0`=0, `u_rnw`=1. Stay in STAT while bit0 = 0.
2. RLAT: `u_cs`=0, `u_a0`=1, `u_rnw`=1. Latch `u_rdata`.
3. POP: `u_cs`=1, `u_a0`=1, `u_rnw`=1. This frees the UART receiver.

Data is never sampled in POP, because the UART may clear its data output inside the strobe cycle.

TX byte send:
1. TSTAT: status read. Wait while bit1 = 1.
2. TWR: `u_cs`=1, `u_a0`=1, `u_rnw`=0, `u_wdata`=byte. Lasts exactly one cycle.

States: IDLE/CMD (fetch), AH, AL, LEN, WDATA (fetch, then `m_we` cycle), RDREQ (`m_re`), RDCAP (capture `m_rdata`), TXSTAT, TXWR, GO.
- After the last TX byte of a command the FSM returns to CMD fetch.
- `cpu_hold` is high from the AH state of `W`/`R` until the reply has been sent.
- If `HOLD_AT_RESET`=1, `cpu_hold` also stays high from reset until the first `G`.
- `G` clears `cpu_hold` in the same cycle that `go` pulses.

## Timing
Reset values:
- `u_cs`=0, `u_a0`=0, `u_rnw`=1, `u_wdata`=0.
- `m_we`=0, `m_re`=0, `m_addr`=0, `m_wdata`=0.
- `go`=0, `go_addr`=0.
- `cpu_hold`=`HOLD_AT_RESET`.
- FSM = IDLE.

Cycle-level rules:
- `m_we` is high for exactly one cycle per data byte. `m_addr` and `m_wdata` are stable in that cycle.
- `m_re` is high for one cycle. `m_rdata` is captured on the next posedge.
- `u_cs` is never high for two consecutive data-register cycles.
- Reset mid-command aborts immediately:
  - the partial write count is lost;
  - no reply is sent;
  - `cpu_hold` returns to its reset value.
- A write pulse in flight at reset is cut and not re-issued.
- RX bytes arriving while the loader is sending a reply stay in the UART. They are fetched only when the FSM next reaches a fetch state; the UART has a single buffer, so the host must not stream ahead of replies.

## Structure
- Package `serial_loader_pkg`:
  - FSM state enum;
  - command byte constants `CMD_W`, `CMD_R`, `CMD_G`;
  - reply constants `ACK_GO` (0x2E), `NAK` (0x3F);
  - UART status bit indices.
- One sub-module, `uart_port_master`. It owns the STAT/RLAT/POP and TSTAT/TWR sequencing and offers `get_req`/`get_ack`/`get_byte` and `put_req`/`put_ack`/`put_byte` handshakes to the command FSM.

## Test plan
The bench uses a UART register model with an injectable RX queue and a TX log, plus a 64 KiB memory model.
- `W` 0x12 0x00 0x03 {0x01,0x02,0x03}: memory 0x1200..0x1202 = 01 02 03; reply 0x06; exactly 3 `m_we` pulses.
- `W` 0xFF 0xFF 0x02 {0xAA,0x55}: writes go to 0xFFFF and then 0x0000; reply 0xFF.
- With memory preset 0x2000..0x2003 = DE AD BE EF, `R` 0x20 0x00 0x04: TX log = DE AD BE EF. No TWR is issued while tx_busy = 1.
- `W` with LEN = 0x00: exactly 256 writes, with a correct mod-256 checksum reply.
- `G` 0x80 0x00: `go` high for one cycle, `go_addr` = 0x8000, `cpu_hold` falls, reply 0x2E. Command byte 0x41 gives reply 0x3F.
- Assert `reset` low after 2 of 3 `W` data bytes: the FSM returns to IDLE, no reply is sent, no further `m_we` pulses occur, and `cpu_hold` = 1. A fresh `W` then completes normally.

Source files
------------

// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg
// Shared definitions for the serial loader: FSM state encodings, host
// command bytes, reply bytes, UART status bit positions and a small helper
// that turns the protocol LEN byte into a transfer count.
package serial_loader_pkg;

  // Command FSM states.
  typedef enum logic [3:0] {
    S_IDLE,   // fetch command byte
    S_AH,     // fetch address high byte
    S_AL,     // fetch address low byte
    S_LEN,    // fetch length byte
    S_WDATA,  // fetch one write data byte
    S_WSTB,   // memory write strobe
    S_RDREQ,  // memory read strobe
    S_RDCAP,  // capture memory read data
    S_TX,     // hand a reply byte to the UART port
    S_GO      // release the CPU
  } state_t;

  // UART port sequencer states.
  typedef enum logic [2:0] {
    P_IDLE,   // bus quiet, waiting for a request
    P_STAT,   // status read, wait for rx_full
    P_RLAT,   // data register addressed, byte latched
    P_POP,    // data register strobe frees the receiver
    P_TSTAT,  // status read, wait for tx_busy to clear
    P_TWR     // data register write
  } port_state_t;

  localparam logic [7:0] CMD_W  = 8'h57;
  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] CMD_G  = 8'h47;
  localparam logic [7:0] ACK_GO = 8'h2E;
  localparam logic [7:0] NAK    = 8'h3F;

  localparam int ST_RX_FULL = 0;
  localparam int ST_TX_BUSY = 1;

  // LEN = 0 encodes a full 256-byte transfer.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/serial_loader_if.sv
// serial_loader_if
// Bundles the loader's UART register bus, memory bus and CPU control lines.
//   master : the loader (drives u_cs/u_a0/u_rnw/u_wdata, m_addr/m_wdata/
//            m_we/m_re, cpu_hold/go/go_addr; receives u_rdata, m_rdata)
//   slave  : the UART, memory and CPU side
interface serial_loader_if;
  logic        u_cs;
  logic        u_a0;
  logic        u_rnw;
  logic [7:0]  u_wdata;
  logic [7:0]  u_rdata;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_we;
  logic        m_re;
  logic [7:0]  m_rdata;
  logic        cpu_hold;
  logic        go;
  logic [15:0] go_addr;

  modport master (
    output u_cs, u_a0, u_rnw, u_wdata,
    input  u_rdata,
    output m_addr, m_wdata, m_we, m_re,
    input  m_rdata,
    output cpu_hold, go, go_addr
  );

  modport slave (
    input  u_cs, u_a0, u_rnw, u_wdata,
    output u_rdata,
    input  m_addr, m_wdata, m_we, m_re,
    output m_rdata,
    input  cpu_hold, go, go_addr
  );
endinterface

// File: rtl/serial_loader_uart_port_master.sv
// uart_port_master
// Sequences UART register accesses on behalf of the command FSM.
//   clk, reset          : clock, asynchronous active-low reset
//   get_req/ack/byte    : fetch one RX byte (STAT -> RLAT -> POP)
//   put_req/ack/byte    : send one TX byte (TSTAT -> TWR)
//   u_cs/u_a0/u_rnw     : UART register strobes
//   u_wdata, u_rdata    : UART write / combinational read data
// The requester holds req high until ack; ack is a single-cycle pulse.
module uart_port_master
  import serial_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       get_req,
  output logic       get_ack,
  output logic [7:0] get_byte,
  input  logic       put_req,
  output logic       put_ack,
  input  logic [7:0] put_byte,
  output logic       u_cs,
  output logic       u_a0,
  output logic       u_rnw,
  output logic [7:0] u_wdata,
  input  logic [7:0] u_rdata
);

  port_state_t state_reg, state_next;
  logic [7:0]  rx_byte_reg;
  logic [7:0]  tx_byte_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= P_IDLE;
      rx_byte_reg <= 8'h00;
      tx_byte_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      // Data is latched in RLAT, never in POP: the UART may drop its data
      // output during the pop strobe.
      if (state_reg == P_RLAT) begin
        rx_byte_reg <= u_rdata;
      end
      if (state_reg == P_IDLE && put_req) begin
        tx_byte_reg <= put_byte;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    u_cs       = 1'b0;
    u_a0       = 1'b0;
    u_rnw      = 1'b1;
    get_ack    = 1'b0;
    put_ack    = 1'b0;
    case (state_reg)
      P_IDLE: begin
        if (put_req) begin
          state_next = P_TSTAT;
        end else if (get_req) begin
          state_next = P_STAT;
        end
      end
      P_STAT: begin
        u_cs = 1'b1;
        if (u_rdata[ST_RX_FULL]) begin
          state_next = P_RLAT;
        end
      end
      P_RLAT: begin
        u_a0       = 1'b1;
        state_next = P_POP;
      end
      P_POP: begin
        u_cs       = 1'b1;
        u_a0       = 1'b1;
        get_ack    = 1'b1;
        state_next = P_IDLE;
      end
      P_TSTAT: begin
        u_cs = 1'b1;
        if (!u_rdata[ST_TX_BUSY]) begin
          state_next = P_TWR;
        end
      end
      P_TWR: begin
        u_cs       = 1'b1;
        u_a0       = 1'b1;
        u_rnw      = 1'b0;
        put_ack    = 1'b1;
        state_next = P_IDLE;
      end
      default: state_next = P_IDLE;
    endcase
  end

  // Returning through P_IDLE after POP/TWR guarantees u_cs never stays
  // high on the data register for two consecutive cycles.
  assign u_wdata  = tx_byte_reg;
  assign get_byte = rx_byte_reg;

endmodule

// File: rtl/serial_loader.sv
// serial_loader
// UART-driven bus-master monitor. Decodes W (write), R (read) and G (go)
// host commands, drives the memory bus and holds/releases the CPU.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : serial_loader_if.master (UART regs, memory bus, CPU control)
// HOLD_AT_RESET keeps cpu_hold asserted from reset until the first G.
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic clk,
  input  logic reset,
  serial_loader_if.master bus
);

  state_t      state_reg, state_next;
  logic [7:0]  cmd_reg;
  logic [7:0]  data_reg;
  logic [7:0]  sum_reg;
  logic [7:0]  tx_byte_reg;
  logic [15:0] addr_reg;
  logic [15:0] go_addr_reg;
  logic [8:0]  count_reg;
  logic        hold_base_reg;   // reset-time hold, cleared by the first G
  logic        busy_hold_reg;   // hold while a W/R command is in progress

  logic        get_req, get_ack, put_req, put_ack;
  logic [7:0]  get_byte;
  logic        cmd_is_bus;
  logic        cmd_is_known;

  assign cmd_is_bus   = (get_byte == CMD_W) || (get_byte == CMD_R);
  assign cmd_is_known = cmd_is_bus || (get_byte == CMD_G);

  uart_port_master port_i (
    .clk      (clk),
    .reset    (reset),
    .get_req  (get_req),
    .get_ack  (get_ack),
    .get_byte (get_byte),
    .put_req  (put_req),
    .put_ack  (put_ack),
    .put_byte (tx_byte_reg),
    .u_cs     (bus.u_cs),
    .u_a0     (bus.u_a0),
    .u_rnw    (bus.u_rnw),
    .u_wdata  (bus.u_wdata),
    .u_rdata  (bus.u_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    get_req    = 1'b0;
    put_req    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        get_req = 1'b1;
        if (get_ack) begin
          state_next = cmd_is_known ? S_AH : S_TX;
        end
      end
      S_AH: begin
        get_req = 1'b1;
        if (get_ack) state_next = S_AL;
      end
      S_AL: begin
        get_req = 1'b1;
        if (get_ack) state_next = (cmd_reg == CMD_G) ? S_GO : S_LEN;
      end
      S_LEN: begin
        get_req = 1'b1;
        if (get_ack) state_next = (cmd_reg == CMD_W) ? S_WDATA : S_RDREQ;
      end
      S_WDATA: begin
        get_req = 1'b1;
        if (get_ack) state_next = S_WSTB;
      end
      S_WSTB:  state_next = (count_reg == 9'd1) ? S_TX : S_WDATA;
      S_RDREQ: state_next = S_RDCAP;
      S_RDCAP: state_next = S_TX;
      S_TX: begin
        put_req = 1'b1;
        if (put_ack) begin
          // Only R streams multiple replies; everything else ends here.
          if (cmd_reg == CMD_R && count_reg != 9'd1) begin
            state_next = S_RDREQ;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_GO:    state_next = S_TX;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_reg       <= 8'h00;
      data_reg      <= 8'h00;
      sum_reg       <= 8'h00;
      tx_byte_reg   <= 8'h00;
      addr_reg      <= 16'h0000;
      go_addr_reg   <= 16'h0000;
      count_reg     <= 9'd0;
      hold_base_reg <= HOLD_AT_RESET;
      busy_hold_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (get_ack) begin
            cmd_reg <= get_byte;
            if (cmd_is_bus) busy_hold_reg <= 1'b1;
            if (!cmd_is_known) tx_byte_reg <= NAK;
          end
        end
        S_AH: begin
          if (get_ack) addr_reg[15:8] <= get_byte;
        end
        S_AL: begin
          if (get_ack) begin
            addr_reg[7:0] <= get_byte;
            if (cmd_reg == CMD_G) begin
              // Hold drops on the same edge that enters S_GO, so cpu_hold
              // falls in the cycle go pulses.
              go_addr_reg   <= {addr_reg[15:8], get_byte};
              hold_base_reg <= 1'b0;
            end
          end
        end
        S_LEN: begin
          if (get_ack) begin
            count_reg <= len_to_count(get_byte);
            sum_reg   <= 8'h00;
          end
        end
        S_WDATA: begin
          if (get_ack) data_reg <= get_byte;
        end
        S_WSTB: begin
          addr_reg    <= addr_reg + 16'd1;
          count_reg   <= count_reg - 9'd1;
          sum_reg     <= sum_reg + data_reg;
          tx_byte_reg <= sum_reg + data_reg;
        end
        S_RDCAP: begin
          tx_byte_reg <= bus.m_rdata;
        end
        S_TX: begin
          if (put_ack) begin
            if (cmd_reg == CMD_R) begin
              addr_reg  <= addr_reg + 16'd1;
              count_reg <= count_reg - 9'd1;
            end
            if (state_next == S_IDLE) busy_hold_reg <= 1'b0;
          end
        end
        S_GO: begin
          tx_byte_reg <= ACK_GO;
        end
        default: ;
      endcase
    end
  end

  assign bus.m_addr   = addr_reg;
  assign bus.m_wdata  = data_reg;
  assign bus.m_we     = (state_reg == S_WSTB);
  assign bus.m_re     = (state_reg == S_RDREQ);
  assign bus.go       = (state_reg == S_GO);
  assign bus.go_addr  = go_addr_reg;
  assign bus.cpu_hold = hold_base_reg | busy_hold_reg;

endmodule
